// File: rtl/frame_buffer_writer_pkg.sv
// Shared types for the frame buffer writer: FSM states, FIFO entry layout, pixel type
// and the line-offset helper used for framebuffer address generation.
package frame_buffer_writer_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        CLEAR,
        FLUSH,
        SWAP_WAIT
    } state_t;

    typedef logic [15:0] rgb565_t;

    typedef struct packed {
        logic [31:0] addr;
        rgb565_t     data;
    } fifo_entry_t;

    // 640 is decomposed as 512+128 so the default geometry needs no multiplier.
    function automatic logic [31:0] line_offset(input logic [8:0] y, input int h_res);
        logic [31:0] y32;
        y32 = {23'd0, y};
        if (h_res == 640)
            return (y32 << 9) + (y32 << 7);
        return y32 * 32'(h_res);
    endfunction

endpackage

// File: rtl/frame_buffer_writer_sync_fifo.sv
// Synchronous FIFO, 1-cycle write-to-read latency, registered storage; pushes while full
// and pops while empty are dropped, and a push/pop pair in one cycle is allowed.
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame_buffer_writer.sv
// Double-buffered pixel/clear writer to SDRAM over Avalon-MM; pixel reaches avm_write one
// cycle after accept. px_ready drops when the write FIFO is full or the FSM is busy.
module frame_buffer_writer
    import frame_buffer_writer_pkg::*;
#(
    parameter int          H_RES      = H_RES_DEF,
    parameter int          V_RES      = V_RES_DEF,
    parameter logic [31:0] BUF0_BASE  = 32'h0000_0000,
    parameter logic [31:0] BUF1_BASE  = 32'h0009_6000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clock_clk,
    input  logic        reset_reset_n,
    input  logic        px_valid,
    output logic        px_ready,
    input  logic [9:0]  px_x,
    input  logic [8:0]  px_y,
    input  logic [15:0] px_color,
    input  logic        frame_done,
    input  logic        clear_start,
    input  logic [15:0] clear_color,
    input  logic        vga_vs_n,
    output logic [31:0] frame_buffer_ptr,
    output logic        frame_swapped,
    output logic        busy,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [15:0] avm_writedata,
    output logic [1:0]  avm_byteenable,
    input  logic        avm_waitrequest
);
    localparam logic [18:0] LAST_IDX = 19'(H_RES * V_RES - 1);

    state_t      state;
    logic [31:0] back_base;
    logic [18:0] clr_idx;
    rgb565_t     clr_color;
    logic        done_pend;
    logic        vs_q;

    fifo_entry_t push_entry;
    fifo_entry_t head;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        accept;
    logic        in_range;

    assign px_ready = ((state == IDLE) || (state == DRAW)) && !full && reset_reset_n;
    assign accept   = px_valid && px_ready;
    assign in_range = (32'(px_x) < 32'(H_RES)) && (32'(px_y) < 32'(V_RES));

    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (state == CLEAR) begin
            push            = !full;
            push_entry.addr = back_base + {12'd0, clr_idx, 1'b0};
            push_entry.data = clr_color;
        end else begin
            push            = accept && in_range;
            push_entry.addr = back_base + ((line_offset(px_y, H_RES) + 32'(px_x)) << 1);
            push_entry.data = px_color;
        end
    end

    assign pop            = !empty && !avm_waitrequest;
    assign avm_write      = !empty;
    assign avm_address    = head.addr;
    assign avm_writedata  = head.data;
    assign avm_byteenable = 2'b11;
    assign busy           = (state != IDLE) || !empty;

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clock_clk),
        .rst_n (reset_reset_n),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            state            <= IDLE;
            clr_idx          <= '0;
            clr_color        <= '0;
            done_pend        <= 1'b0;
            frame_buffer_ptr <= BUF0_BASE;
            back_base        <= BUF1_BASE;
            frame_swapped    <= 1'b0;
            vs_q             <= 1'b1;
        end else begin
            vs_q          <= vga_vs_n;
            frame_swapped <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        clr_color <= clear_color;
                        clr_idx   <= '0;
                        done_pend <= frame_done;
                        state     <= CLEAR;
                    end else if (frame_done) begin
                        state <= FLUSH;
                    end else if (accept) begin
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if (frame_done)
                        state <= FLUSH;
                end
                CLEAR: begin
                    if (!full) begin
                        if (clr_idx == LAST_IDX) begin
                            clr_idx   <= '0;
                            done_pend <= 1'b0;
                            state     <= done_pend ? FLUSH : IDLE;
                        end else begin
                            clr_idx <= clr_idx + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (empty)
                        state <= SWAP_WAIT;
                end
                SWAP_WAIT: begin
                    // Only an edge seen entirely within SWAP_WAIT counts.
                    if (vs_q && !vga_vs_n) begin
                        frame_buffer_ptr <= back_base;
                        back_base        <= frame_buffer_ptr;
                        frame_swapped    <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Bench for frame_buffer_writer: vector table, hand-written corner sequences and
// randomized traffic scored against a queue-based model of expected SDRAM writes.
module tb_frame_buffer_writer;

    localparam int H = 640;
    localparam int V = 16;

    logic        clk = 1'b0;
    logic        reset_reset_n;
    logic        px_valid;
    logic        px_ready;
    logic [9:0]  px_x;
    logic [8:0]  px_y;
    logic [15:0] px_color;
    logic        frame_done;
    logic        clear_start;
    logic [15:0] clear_color;
    logic        vga_vs_n;
    logic [31:0] frame_buffer_ptr;
    logic        frame_swapped;
    logic        busy;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [15:0] avm_writedata;
    logic [1:0]  avm_byteenable;
    logic        avm_waitrequest;

    always #5 clk = ~clk;

    frame_buffer_writer #(
        .H_RES      (H),
        .V_RES      (V),
        .BUF0_BASE  (32'h0000_0000),
        .BUF1_BASE  (32'h0009_6000),
        .FIFO_DEPTH (8)
    ) dut (
        .clock_clk        (clk),
        .reset_reset_n    (reset_reset_n),
        .px_valid         (px_valid),
        .px_ready         (px_ready),
        .px_x             (px_x),
        .px_y             (px_y),
        .px_color         (px_color),
        .frame_done       (frame_done),
        .clear_start      (clear_start),
        .clear_color      (clear_color),
        .vga_vs_n         (vga_vs_n),
        .frame_buffer_ptr (frame_buffer_ptr),
        .frame_swapped    (frame_swapped),
        .busy             (busy),
        .avm_address      (avm_address),
        .avm_write        (avm_write),
        .avm_writedata    (avm_writedata),
        .avm_byteenable   (avm_byteenable),
        .avm_waitrequest  (avm_waitrequest)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [15:0] c;
        logic        push;
        logic [31:0] addr;
    } vec_t;

    wr_t         exp_q[$];
    vec_t        vecs[7];
    int          tests = 0;
    int          fails = 0;
    int          wr_count = 0;
    logic [31:0] model_front;
    logic [31:0] model_back;
    logic        last_acc;
    logic        rand_wr;
    logic        prev_stall;
    logic [31:0] p_addr;
    logic [15:0] p_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        wr_t e;
        if (reset_reset_n) begin
            if (prev_stall) begin
                check("hold_write", 32'(avm_write), 32'd1);
                check("hold_addr", avm_address, p_addr);
                check("hold_data", 32'(avm_writedata), 32'(p_data));
            end
            if (avm_write && !avm_waitrequest) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write",
                             avm_address, avm_writedata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", avm_address, e.a);
                    check("wr_data", 32'(avm_writedata), 32'(e.d));
                end
            end
            prev_stall = avm_write && avm_waitrequest;
            p_addr     = avm_address;
            p_data     = avm_writedata;
        end else begin
            prev_stall = 1'b0;
        end
    endtask

    // Monitor and model run at the falling edge; stimulus changes 1 ns after the rising edge.
    task automatic tick();
        wr_t w;
        @(negedge clk);
        monitor();
        last_acc = reset_reset_n && px_valid && px_ready;
        if (last_acc && (32'(px_x) < H) && (32'(px_y) < V)) begin
            w.a = model_back + 32'd2 * (32'(px_y) * 32'(H) + 32'(px_x));
            w.d = px_color;
            exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
        if (rand_wr)
            avm_waitrequest = ($urandom_range(0, 2) == 0);
    endtask

    task automatic send_px(input logic [9:0] x, input logic [8:0] y, input logic [15:0] c);
        px_x     = x;
        px_y     = y;
        px_color = c;
        px_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (last_acc)
                break;
        end
        check("px_accept", 32'(last_acc), 32'd1);
        px_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        tick();
        check("write_idle", 32'(avm_write), 32'd0);
    endtask

    task automatic pulse_clear(input logic [15:0] color, input logic with_done);
        wr_t w;
        for (int i = 0; i < H * V; i++) begin
            w.a = model_back + 32'(2 * i);
            w.d = color;
            exp_q.push_back(w);
        end
        clear_color = color;
        clear_start = 1'b1;
        frame_done  = with_done;
        tick();
        clear_start = 1'b0;
        frame_done  = 1'b0;
    endtask

    task automatic vs_swap(input logic [31:0] exp_ptr);
        int cnt;
        cnt = 0;
        vga_vs_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (frame_swapped)
                cnt++;
        end
        vga_vs_n = 1'b1;
        check("swap_pulses", 32'(cnt), 32'd1);
        {model_front, model_back} = {model_back, model_front};
        check("ptr_after_swap", frame_buffer_ptr, exp_ptr);
        check("idle_after_swap", 32'(busy), 32'd0);
    endtask

    task automatic swap_cycle(input logic [31:0] exp_ptr);
        avm_waitrequest = 1'b1;
        send_px(10'd10, 9'd1, 16'h1111);
        send_px(10'd20, 9'd2, 16'h2222);
        send_px(10'd30, 9'd3, 16'h3333);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        // A vsync edge during FLUSH must not swap.
        vga_vs_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_swap_in_flush", 32'(frame_swapped), 32'd0);
        end
        vga_vs_n = 1'b1;
        tick();
        tick();
        check("ptr_before_drain", frame_buffer_ptr, model_front);
        check("queued_writes", 32'(exp_q.size()), 32'd3);
        avm_waitrequest = 1'b0;
        wait_drain(50);
        tick();
        tick();
        check("swap_wait_busy", 32'(busy), 32'd1);
        check("ptr_held_in_wait", frame_buffer_ptr, model_front);
        vs_swap(exp_ptr);
    endtask

    initial begin
        int idx;
        reset_reset_n   = 1'b0;
        px_valid        = 1'b0;
        px_x            = '0;
        px_y            = '0;
        px_color        = '0;
        frame_done      = 1'b0;
        clear_start     = 1'b0;
        clear_color     = '0;
        vga_vs_n        = 1'b1;
        avm_waitrequest = 1'b0;
        rand_wr         = 1'b0;
        prev_stall      = 1'b0;
        last_acc        = 1'b0;
        p_addr          = '0;
        p_data          = '0;
        model_front     = 32'h0000_0000;
        model_back      = 32'h0009_6000;

        vecs[0] = '{10'd3,    9'd2,   16'hF800, 1'b1, 32'h0009_6A06};
        vecs[1] = '{10'd640,  9'd0,   16'h07E0, 1'b0, 32'h0};
        vecs[2] = '{10'd0,    9'd0,   16'h1234, 1'b1, 32'h0009_6000};
        vecs[3] = '{10'd639,  9'd15,  16'hABCD, 1'b1, 32'h0009_AFFE};
        vecs[4] = '{10'd0,    9'd16,  16'h5555, 1'b0, 32'h0};
        vecs[5] = '{10'd1023, 9'd511, 16'hFFFF, 1'b0, 32'h0};
        vecs[6] = '{10'd100,  9'd1,   16'h0F0F, 1'b1, 32'h0009_65C8};

        // Reset state
        repeat (3) tick();
        check("rst_px_ready", 32'(px_ready), 32'd0);
        check("rst_avm_write", 32'(avm_write), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ptr", frame_buffer_ptr, 32'h0000_0000);
        check("rst_swapped", 32'(frame_swapped), 32'd0);
        reset_reset_n = 1'b1;
        tick();
        check("ready_after_rst", 32'(px_ready), 32'd1);
        check("byteenable", 32'(avm_byteenable), 32'd3);

        // Full-buffer clear; stray clear_start/frame_done mid-clear must be ignored
        wr_count = 0;
        pulse_clear(16'h001F, 1'b0);
        repeat (50) tick();
        check("clear_px_ready", 32'(px_ready), 32'd0);
        frame_done = 1'b1;
        tick();
        frame_done  = 1'b0;
        clear_color = 16'hDEAD;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        wait_drain(12000);
        check("clear_count", 32'(wr_count), 32'(H * V));
        tick();
        check("clear_idle", 32'(busy), 32'd0);
        check("clear_ptr", frame_buffer_ptr, 32'h0000_0000);

        // Vector table: latency, address and out-of-range discard
        for (int i = 0; i < 7; i++) begin
            px_x     = vecs[i].x;
            px_y     = vecs[i].y;
            px_color = vecs[i].c;
            px_valid = 1'b1;
            tick();
            check("vec_accept", 32'(last_acc), 32'd1);
            px_valid = 1'b0;
            check("vec_write", 32'(avm_write), 32'(vecs[i].push));
            if (vecs[i].push) begin
                check("vec_addr", avm_address, vecs[i].addr);
                check("vec_data", 32'(avm_writedata), 32'(vecs[i].c));
            end
            tick();
            check("vec_single", 32'(avm_write), 32'd0);
        end

        // Stall: 10 pixels offered against a blocked bus
        avm_waitrequest = 1'b1;
        idx      = 0;
        px_x     = 10'd0;
        px_y     = 9'd0;
        px_color = 16'hA000;
        px_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (last_acc) begin
                idx++;
                px_x     = 10'(idx * 7);
                px_y     = 9'(idx);
                px_color = 16'hA000 + 16'(idx);
                if (idx >= 10)
                    px_valid = 1'b0;
            end
        end
        check("stall_accepts", 32'(idx), 32'd8);
        check("stall_ready", 32'(px_ready), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        avm_waitrequest = 1'b0;
        for (int c = 0; c < 40 && idx < 10; c++) begin
            tick();
            if (last_acc) begin
                idx++;
                px_x     = 10'(idx * 7);
                px_y     = 9'(idx);
                px_color = 16'hA000 + 16'(idx);
                if (idx >= 10)
                    px_valid = 1'b0;
            end
        end
        check("stall_all_accepted", 32'(idx), 32'd10);
        wait_drain(40);

        // Randomized traffic with random bus stalls
        rand_wr = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (!px_valid || last_acc) begin
                px_valid = ($urandom_range(0, 3) != 0);
                px_x     = 10'($urandom_range(0, 700));
                px_y     = 9'($urandom_range(0, 20));
                px_color = 16'($urandom);
            end
            tick();
        end
        px_valid        = 1'b0;
        rand_wr         = 1'b0;
        avm_waitrequest = 1'b0;
        wait_drain(100);

        // Two full swap cycles
        swap_cycle(32'h0009_6000);
        swap_cycle(32'h0000_0000);

        // clear_start and frame_done together: clear first, then flush and swap
        wr_count = 0;
        pulse_clear(16'hBEEF, 1'b1);
        wait_drain(12000);
        check("combo_clear_count", 32'(wr_count), 32'(H * V));
        tick();
        tick();
        check("combo_swap_wait", 32'(busy), 32'd1);
        check("combo_no_early_swap", frame_buffer_ptr, 32'h0000_0000);
        vs_swap(32'h0009_6000);

        // Reset in the middle of a stalled clear
        avm_waitrequest = 1'b1;
        pulse_clear(16'h7777, 1'b0);
        repeat (5) tick();
        reset_reset_n = 1'b0;
        tick();
        check("mid_rst_write", 32'(avm_write), 32'd0);
        check("mid_rst_ptr", frame_buffer_ptr, 32'h0000_0000);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(px_ready), 32'd0);
        exp_q.delete();
        model_front     = 32'h0000_0000;
        model_back      = 32'h0009_6000;
        reset_reset_n   = 1'b1;
        avm_waitrequest = 1'b0;
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);
        send_px(10'd3, 9'd2, 16'hF800);
        check("post_rst_write", 32'(avm_write), 32'd1);
        check("post_rst_addr", avm_address, 32'h0009_6A06);
        wait_drain(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
